// File: rtl/accelerant_pkg.sv
// Shared definitions for the Accelerant mesh configuration sequencer.
//   seq_state_t      : sequencer FSM states
//   INSTR_*          : PE instruction encodings carried on pe_instruction
//   DEFAULT_PIPE_LAT : PE input-register plus output-register latency
package accelerant_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam logic [3:0] INSTR_FADD    = 4'b0000;
    localparam logic [3:0] INSTR_FMUL    = 4'b0001;
    // Data-only write: the PE updates its internal register but keeps its configuration.
    localparam logic [3:0] INSTR_DATA_WR = 4'b0010;
    localparam logic [3:0] INSTR_FMA     = 4'b0011;
    localparam logic [3:0] INSTR_SYS_FMA = 4'b1010;

    localparam int DEFAULT_PIPE_LAT = 2;

endpackage

// File: rtl/mesh_config_sequencer_run_timer.sv
// run_timer: times one compute run of the mesh.
//   clk, reset     : clock, asynchronous active-low reset
//   start_i, len_i : begin a run of len_i cycles (len_i is never 0 here)
//   abort_i        : cancel the run and flush the latency pipe immediately
//   run_active_o   : high for exactly len_i cycles after start_i
//   out_valid_o    : run_active_o delayed by PIPE_LAT cycles
//   run_end_o      : last cycle of run_active_o
//   drain_end_o    : last cycle of the PIPE_LAT-cycle drain after the run
module run_timer #(
    parameter int PIPE_LAT  = 2,
    parameter int RUN_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [RUN_CNT_W-1:0] len_i,
    input  logic                 abort_i,
    output logic                 run_active_o,
    output logic                 out_valid_o,
    output logic                 run_end_o,
    output logic                 drain_end_o
);

    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

    logic                 run_active_q, run_active_d;
    logic [RUN_CNT_W-1:0] cnt_q, cnt_d;
    logic [PIPE_LAT-1:0]  pipe_q, pipe_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    always_comb begin
        // The down-counter holds the cycles still to run including the current one.
        run_end_o    = run_active_q && (cnt_q == RUN_CNT_W'(1));
        drain_end_o  = (drain_q == DRAIN_W'(1));

        run_active_d = run_active_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        pipe_d       = '0;

        pipe_d[0] = run_active_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (drain_q != '0) begin
            drain_d = drain_q - DRAIN_W'(1);
        end

        if (start_i) begin
            run_active_d = 1'b1;
            cnt_d        = len_i;
        end else if (run_end_o) begin
            run_active_d = 1'b0;
            cnt_d        = '0;
            drain_d      = DRAIN_W'(PIPE_LAT);
        end else if (run_active_q) begin
            cnt_d = cnt_q - RUN_CNT_W'(1);
        end

        // Abort also empties the latency pipe so out_valid drops with run_active.
        if (abort_i) begin
            run_active_d = 1'b0;
            cnt_d        = '0;
            drain_d      = '0;
            pipe_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_active_q <= 1'b0;
            cnt_q        <= '0;
            pipe_q       <= '0;
            drain_q      <= '0;
        end else begin
            run_active_q <= run_active_d;
            cnt_q        <= cnt_d;
            pipe_q       <= pipe_d;
            drain_q      <= drain_d;
        end
    end

    assign run_active_o = run_active_q;
    assign out_valid_o  = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/mesh_config_sequencer.sv
// mesh_config_sequencer: programs the PEs of the Accelerant mesh, then times one compute run.
// Optional feature macro: CFG_CHECKSUM_EN adds cfg_checksum, the XOR of cfg_data over every
// accepted in-range entry (cleared by reset and by cfg_clear).
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready           : config entry stream (cfg_pe, cfg_instr, cfg_data, cfg_last)
//   cfg_clear                     : request a PE clear pulse (IDLE only)
//   start, run_len, abort         : run control
//   pe_reset, pe_load             : PE clear pulse and one-hot load strobe
//   pe_instruction, pe_data       : shared PE instruction / internal data buses
//   run_active, out_valid, done   : run timing outputs
//   cfg_err                       : sticky out-of-range PE index flag
//   dbg_state_o                   : current FSM state
//
// Handshake: an entry transfers on a rising edge where cfg_valid && cfg_ready are both high;
// cfg_ready does not depend on cfg_valid, and upstream must hold the entry stable until then.
module mesh_config_sequencer
    import accelerant_pkg::*;
#(
    parameter int NUM_PES   = 16,
    parameter int PE_IDX_W  = $clog2(NUM_PES),
    parameter int PIPE_LAT  = DEFAULT_PIPE_LAT,
    parameter int RUN_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [PE_IDX_W-1:0]  cfg_pe,
    input  logic [3:0]           cfg_instr,
    input  logic [31:0]          cfg_data,
    input  logic                 cfg_last,
    input  logic                 cfg_clear,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RUN_CNT_W-1:0] run_len,
    output logic                 pe_reset,
    output logic [NUM_PES-1:0]   pe_load,
    output logic [3:0]           pe_instruction,
    output logic [31:0]          pe_data,
    output logic                 run_active,
    output logic                 out_valid,
    output logic                 done,
    output logic                 cfg_err,
`ifdef CFG_CHECKSUM_EN
    output logic [31:0]          cfg_checksum,
`endif
    output seq_state_t           dbg_state_o
);

    seq_state_t         state_q, state_d;
    logic               ready_en_q;
    logic [NUM_PES-1:0] pe_load_q, pe_load_d;
    logic [3:0]         pe_instr_q;
    logic [31:0]        pe_data_q;
    logic               pe_reset_q;
    logic               done_q, done_d;
    logic               cfg_err_q;

    logic in_idle, cfg_acc, pe_in_range, load_acc;
    logic start_acc, run_go, abort_acc, clear_acc;
    logic run_end, drain_end;

    always_comb begin
        in_idle     = (state_q == IDLE);
        // ready_en_q holds cfg_ready low for the first cycle after reset release.
        cfg_ready   = in_idle && !start && !cfg_clear && ready_en_q;
        cfg_acc     = cfg_valid && cfg_ready;
        pe_in_range = ({1'b0, cfg_pe} < (PE_IDX_W + 1)'(NUM_PES));
        load_acc    = cfg_acc && pe_in_range;
        start_acc   = start && (state_q == IDLE || state_q == ARMED);
        run_go      = start_acc && (run_len != '0);
        abort_acc   = abort && (state_q == RUN || state_q == DRAIN);
        clear_acc   = cfg_clear && in_idle;
    end

    always_comb begin
        pe_load_d = '0;
        for (int i = 0; i < NUM_PES; i++) begin
            pe_load_d[i] = load_acc && (cfg_pe == PE_IDX_W'(i));
        end
    end

    run_timer #(
        .PIPE_LAT  (PIPE_LAT),
        .RUN_CNT_W (RUN_CNT_W)
    ) u_run_timer (
        .clk          (clk),
        .reset        (reset),
        .start_i      (run_go),
        .len_i        (run_len),
        .abort_i      (abort_acc),
        .run_active_o (run_active),
        .out_valid_o  (out_valid),
        .run_end_o    (run_end),
        .drain_end_o  (drain_end)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, ARMED: begin
                if (start_acc) begin
                    if (run_go) begin
                        state_d = RUN;
                    end else begin
                        // Zero-length run: finish immediately.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (cfg_acc && cfg_last) begin
                    state_d = ARMED;
                end
            end
            RUN: begin
                if (abort_acc) begin
                    state_d = IDLE;
                end else if (run_end) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_acc) begin
                    state_d = IDLE;
                end else if (drain_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            pe_load_q  <= '0;
            pe_instr_q <= '0;
            pe_data_q  <= '0;
            pe_reset_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            pe_load_q  <= pe_load_d;
            pe_reset_q <= clear_acc;
            done_q     <= done_d;
            // Buses hold their last loaded value between loads.
            if (load_acc) begin
                pe_instr_q <= cfg_instr;
                pe_data_q  <= cfg_data;
            end
            if (clear_acc) begin
                cfg_err_q <= 1'b0;
            end else if (cfg_acc && !pe_in_range) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

`ifdef CFG_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if (clear_acc) begin
            checksum_q <= '0;
        end else if (load_acc) begin
            checksum_q <= checksum_q ^ cfg_data;
        end
    end

    assign cfg_checksum = checksum_q;
`else
    // No checksum state in this build.
`endif

    assign pe_load        = pe_load_q;
    assign pe_instruction = pe_instr_q;
    assign pe_data        = pe_data_q;
    assign pe_reset       = pe_reset_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mesh_config_sequencer.sv
// Testbench for mesh_config_sequencer: directed scenarios plus randomized programs and runs,
// with expected PE events queued by the drivers and checked by a negedge monitor.
module tb_mesh_config_sequencer;
    import accelerant_pkg::*;

    localparam int NUM_PES   = 16;
    localparam int PE_IDX_W  = 5;
    localparam int PIPE_LAT  = 2;
    localparam int RUN_CNT_W = 16;

    localparam logic [1:0] K_LOAD  = 2'd0;
    localparam logic [1:0] K_RESET = 2'd1;
    localparam logic [1:0] K_DONE  = 2'd2;

    typedef struct packed {
        logic [1:0]           kind;
        logic [NUM_PES-1:0]   load;
        logic [3:0]           instr;
        logic [31:0]          data;
        logic [31:0]          chk;
        logic [RUN_CNT_W-1:0] len;
    } exp_t;

    exp_t exp_q[$];

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cfg_valid, cfg_ready, cfg_last, cfg_clear;
    logic [PE_IDX_W-1:0]  cfg_pe;
    logic [3:0]           cfg_instr;
    logic [31:0]          cfg_data;
    logic                 start, abort;
    logic [RUN_CNT_W-1:0] run_len;
    logic                 pe_reset;
    logic [NUM_PES-1:0]   pe_load;
    logic [3:0]           pe_instruction;
    logic [31:0]          pe_data;
    logic                 run_active, out_valid, done, cfg_err;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]          cfg_checksum;
`endif
    seq_state_t           dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          m_armed;
    bit          m_err;
    logic [31:0] m_chk;

    logic [3:0] instr_tab [5];

    mesh_config_sequencer #(
        .NUM_PES   (NUM_PES),
        .PE_IDX_W  (PE_IDX_W),
        .PIPE_LAT  (PIPE_LAT),
        .RUN_CNT_W (RUN_CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_pe         (cfg_pe),
        .cfg_instr      (cfg_instr),
        .cfg_data       (cfg_data),
        .cfg_last       (cfg_last),
        .cfg_clear      (cfg_clear),
        .start          (start),
        .abort          (abort),
        .run_len        (run_len),
        .pe_reset       (pe_reset),
        .pe_load        (pe_load),
        .pe_instruction (pe_instruction),
        .pe_data        (pe_data),
        .run_active     (run_active),
        .out_valid      (out_valid),
        .done           (done),
        .cfg_err        (cfg_err),
`ifdef CFG_CHECKSUM_EN
        .cfg_checksum   (cfg_checksum),
`endif
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: actual=event expected=none", name);
    endtask

    function automatic logic [63:0] all_outputs();
        return {5'd0, cfg_ready, pe_reset, pe_load, pe_instruction, pe_data,
                run_active, out_valid, done, cfg_err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int pe, input logic [3:0] instr, input logic [31:0] data,
                            input bit last);
        int   waited;
        exp_t e;
        cfg_valid = 1'b1;
        cfg_pe    = PE_IDX_W'(pe);
        cfg_instr = instr;
        cfg_data  = data;
        cfg_last  = last;
        #1;
        waited = 0;
        while (!cfg_ready && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!cfg_ready) begin
            check("cfg_ready_timeout", {63'd0, cfg_ready}, 64'd1);
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            #1;
            return;
        end
        if (pe < NUM_PES) begin
            m_chk   = m_chk ^ data;
            e.kind  = K_LOAD;
            e.load  = NUM_PES'(1) << pe;
            e.instr = instr;
            e.data  = data;
            e.chk   = m_chk;
            e.len   = '0;
            exp_q.push_back(e);
        end else begin
            m_err = 1'b1;
        end
        if (last) m_armed = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check("cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
    endtask

    task automatic do_clear();
        exp_t e;
        cfg_clear = 1'b1;
        if (!m_armed) begin
            e      = '0;
            e.kind = K_RESET;
            exp_q.push_back(e);
            m_err  = 1'b0;
            m_chk  = '0;
        end
        next_cycle();
        cfg_clear = 1'b0;
        check("cfg_err_after_clear", {63'd0, cfg_err}, {63'd0, m_err});
    endtask

    // abort_at: 0 = no abort, else abort during the abort_at-th cycle after the start edge.
    task automatic do_start(input int len, input int abort_at);
        exp_t e;
        e      = '0;
        e.kind = K_DONE;
        e.len  = RUN_CNT_W'(len);
        exp_q.push_back(e);
        start   = 1'b1;
        run_len = RUN_CNT_W'(len);
        next_cycle();
        start   = 1'b0;
        m_armed = 1'b0;
        if (len == 0) check("done_len0_next_cycle", {63'd0, done}, 64'd1);
        if (abort_at > 0) begin
            repeat (abort_at - 1) next_cycle();
            abort = 1'b1;
            e = exp_q.pop_back();
            next_cycle();
            abort = 1'b0;
            check("abort_run_active", {63'd0, run_active}, 64'd0);
            check("abort_out_valid", {63'd0, out_valid}, 64'd0);
            check("abort_state", {62'd0, dbg_state}, {62'd0, IDLE});
        end
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            next_cycle();
            waited++;
        end
        if (exp_q.size() != 0) begin
            check("scoreboard_drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        next_cycle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   cyc, ra_cnt, ov_cnt, ra_rise, ov_rise;
    logic prev_ra, prev_ov;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            ra_cnt  = 0;
            ov_cnt  = 0;
            prev_ra = 1'b0;
            prev_ov = 1'b0;
        end else begin
            cyc++;
            if (run_active && !prev_ra) begin
                ra_cnt  = 0;
                ov_cnt  = 0;
                ra_rise = cyc;
            end
            if (out_valid && !prev_ov) ov_rise = cyc;
            if (run_active) ra_cnt++;
            if (out_valid) ov_cnt++;

            if (pe_reset) begin
                if (exp_q.size() == 0) fail_event("unexpected_pe_reset");
                else begin
                    e = exp_q.pop_front();
                    check("pe_reset_kind", 64'(e.kind), 64'(K_RESET));
                end
            end
            if (pe_load != '0) begin
                if (exp_q.size() == 0) fail_event("unexpected_pe_load");
                else begin
                    e = exp_q.pop_front();
                    check("load_kind", 64'(e.kind), 64'(K_LOAD));
                    check("pe_load", 64'(pe_load), 64'(e.load));
                    check("pe_instruction", 64'(pe_instruction), 64'(e.instr));
                    check("pe_data", 64'(pe_data), 64'(e.data));
`ifdef CFG_CHECKSUM_EN
                    check("cfg_checksum", 64'(cfg_checksum), 64'(e.chk));
`endif
                end
            end
            if (done) begin
                if (exp_q.size() == 0) fail_event("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    check("done_kind", 64'(e.kind), 64'(K_DONE));
                    check("run_active_cycles", 64'(ra_cnt), 64'(e.len));
                    check("out_valid_cycles", 64'(ov_cnt), 64'(e.len));
                    check("out_valid_low_at_done", {63'd0, out_valid}, 64'd0);
                    if (e.len != '0) begin
                        check("done_on_out_valid_fall", {63'd0, prev_ov}, 64'd1);
                        check("out_valid_delay", 64'(ov_rise - ra_rise), 64'(PIPE_LAT));
                    end
                end
                ra_cnt = 0;
                ov_cnt = 0;
            end
            if (abort) begin
                ra_cnt = 0;
                ov_cnt = 0;
            end
            prev_ra = run_active;
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n, pe, len, ab;
        bit  last;

        instr_tab = '{INSTR_FADD, INSTR_FMUL, INSTR_DATA_WR, INSTR_FMA, INSTR_SYS_FMA};
        cyc = 0; ra_cnt = 0; ov_cnt = 0; ra_rise = 0; ov_rise = 0;
        prev_ra = 1'b0; prev_ov = 1'b0;
        m_armed = 1'b0; m_err = 1'b0; m_chk = '0;
        reset = 1'b0;
        cfg_valid = 1'b0; cfg_pe = '0; cfg_instr = '0; cfg_data = '0; cfg_last = 1'b0;
        cfg_clear = 1'b0; start = 1'b0; abort = 1'b0; run_len = '0;

        // Reset state and release behaviour.
        repeat (3) next_cycle();
        check("reset_outputs", all_outputs(), 64'd0);
        check("reset_state", {62'd0, dbg_state}, {62'd0, IDLE});
        reset = 1'b1;
        #1;
        check("ready_low_after_release", {63'd0, cfg_ready}, 64'd0);
        next_cycle();
        check("ready_high_next_cycle", {63'd0, cfg_ready}, 64'd1);

        // Out-of-range PE, then clear.
        send_cfg(20, INSTR_FADD, 32'h1234_5678, 1'b0);
        check("oor_no_load", 64'(pe_load), 64'd0);
        do_clear();
        check("clear_pulse", {63'd0, pe_reset}, 64'd1);
        next_cycle();
        check("clear_pulse_one_cycle", {63'd0, pe_reset}, 64'd0);

        // Two-entry program ending in ARMED.
        send_cfg(3, INSTR_FMUL, 32'h3F80_0000, 1'b0);
        check("load_pe3", 64'(pe_load), 64'h0008);
        send_cfg(0, INSTR_FMA, 32'h0, 1'b1);
        check("load_pe0", 64'(pe_load), 64'h0001);
        check("armed_state", {62'd0, dbg_state}, {62'd0, ARMED});
        check("armed_not_ready", {63'd0, cfg_ready}, 64'd0);
        next_cycle();
        check("load_one_cycle", 64'(pe_load), 64'd0);
        check("instr_held", 64'(pe_instruction), 64'(INSTR_FMA));

        // Runs.
        do_start(5, 0);
        wait_drain();
        do_start(0, 0);
        wait_drain();
        do_start(6, 3);
        do_start(2, 0);
        wait_drain();
        do_start(3, 4);
        wait_drain();

`ifdef CFG_CHECKSUM_EN
        do_clear();
        send_cfg(1, INSTR_DATA_WR, 32'hA5A5_A5A5, 1'b0);
        send_cfg(2, INSTR_DATA_WR, 32'h0F0F_0F0F, 1'b0);
        check("checksum_pair", 64'(cfg_checksum), 64'hAAAA_AAAA);
        wait_drain();
`endif

        // Randomized programs and runs.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) == 0) do_clear();
            if (!m_armed) begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(7) == 0) pe = $urandom_range(NUM_PES, NUM_PES + 3);
                    else pe = $urandom_range(NUM_PES - 1);
                    last = (k == n - 1) && ($urandom_range(1) == 1);
                    send_cfg(pe, instr_tab[$urandom_range(4)], $urandom, last);
                end
            end
            if ($urandom_range(2) != 0) begin
                len = $urandom_range(0, 8);
                ab  = 0;
                if (len > 0 && $urandom_range(3) == 0) ab = $urandom_range(1, len + PIPE_LAT);
                do_start(len, ab);
            end else if ($urandom_range(1) == 1) begin
                abort = 1'b1;
                next_cycle();
                abort = 1'b0;
            end
            wait_drain();
            check("rand_state", {62'd0, dbg_state}, {62'd0, (m_armed ? ARMED : IDLE)});
            check("rand_cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
        end

        // Reset in the middle of a run.
        do_start(10, 0);
        repeat (3) next_cycle();
        reset = 1'b0;
        #1;
        check("midrun_reset_outputs", all_outputs(), 64'd0);
        exp_q.delete();
        m_armed = 1'b0; m_err = 1'b0; m_chk = '0;
        next_cycle();
        reset = 1'b1;
        #1;
        check("midrun_ready_low", {63'd0, cfg_ready}, 64'd0);
        next_cycle();
        check("midrun_ready_high", {63'd0, cfg_ready}, 64'd1);
        repeat (15) next_cycle();
        check("final_state", {62'd0, dbg_state}, {62'd0, IDLE});
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
